// File: rtl/clip_pkg.sv
// Shared types and helpers for the clip controller.
package clip_pkg;

  typedef enum logic [1:0] {IDLE, RECORD, PLAY} clip_state_e;

  // Display code for "no clip": the 7-segment driver blanks on this value.
  localparam logic [3:0] CLIP_NONE = 4'hF;

  // Advance the clip selection, wrapping after the last slot.
  function automatic logic [3:0] next_clip(input logic [3:0] sel, input int unsigned num);
    return (sel == 4'(num - 1)) ? 4'd0 : sel + 4'd1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Button conditioning: 2-FF synchroniser, stable-level counter and rising-edge pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            seen_q, press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive synchronised samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Synchroniser, debounce state and registered edge pulse.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      seen_q  <= level_q;
      press_q <= level_q & ~seen_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clip_controller.sv
// Clip controller: button handling, clip selection and the record/play state machine.
module clip_controller
  import clip_pkg::*;
#(
  parameter int unsigned NUM_CLIPS       = 3,
  parameter int unsigned CLIP_ADDR_WIDTH = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         btn_record_i,
  input  logic                         btn_play_i,
  input  logic                         btn_next_i,
  input  logic                         sample_tick_i,
  output logic [3:0]                   play_clip_o,
  output logic [3:0]                   record_clip_o,
  output logic [3:0]                   selected_o,
  output logic [NUM_CLIPS-1:0]         clip_valid_o,
  output logic [4+CLIP_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                         mem_we_o
);

  localparam int unsigned AddrW = CLIP_ADDR_WIDTH;
  localparam int unsigned LenW  = CLIP_ADDR_WIDTH + 1;
  localparam logic [AddrW-1:0] AddrMax = '1;

  logic record_press, play_press, next_press;

  clip_state_e                     state_q, state_d;
  logic [3:0]                      sel_q, sel_d;
  logic [AddrW-1:0]                addr_q, addr_d;
  logic [NUM_CLIPS-1:0]            valid_q, valid_d;
  logic [NUM_CLIPS-1:0][LenW-1:0]  len_q, len_d;
  logic [3:0]                      play_clip_q, play_clip_d;
  logic [3:0]                      record_clip_q, record_clip_d;
  logic [4+AddrW-1:0]              mem_addr_q, mem_addr_d;
  logic                            mem_we_q, mem_we_d;

  logic [NUM_CLIPS-1:0]            sel_hot;
  logic                            sel_valid;
  logic [LenW-1:0]                 sel_len;
  logic [LenW-1:0]                 written;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_record (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .btn_i   (btn_record_i),
    .press_o (record_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_play (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .btn_i   (btn_play_i),
    .press_o (play_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_next (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .btn_i   (btn_next_i),
    .press_o (next_press)
  );

  // Next-state logic for the record/play FSM, clip bookkeeping and registered outputs.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    len_d      = len_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = 1'b0;
    sel_hot    = '0;
    sel_valid  = 1'b0;
    sel_len    = '0;

    for (int n = 0; n < NUM_CLIPS; n++) begin
      if (sel_q == 4'(n)) begin
        sel_hot[n] = 1'b1;
        sel_valid  = valid_q[n];
        sel_len    = len_q[n];
      end
    end

    // Samples stored so far, including one written on this cycle's tick.
    written = {1'b0, addr_q} + {{AddrW{1'b0}}, sample_tick_i};

    unique case (state_q)
      IDLE: begin
        // Starting a record or playback takes priority over a selection change.
        if (record_press) begin
          state_d = RECORD;
          addr_d  = '0;
          valid_d = valid_q & ~sel_hot;
        end else if (play_press && sel_valid) begin
          state_d = PLAY;
          addr_d  = '0;
        end else if (next_press) begin
          sel_d = next_clip(sel_q, NUM_CLIPS);
        end
      end
      RECORD: begin
        if (sample_tick_i) begin
          mem_we_d   = 1'b1;
          mem_addr_d = {sel_q, addr_q};
          if (addr_q != AddrMax) addr_d = addr_q + AddrW'(1);
        end
        if (record_press || (sample_tick_i && addr_q == AddrMax)) begin
          state_d = IDLE;
          for (int n = 0; n < NUM_CLIPS; n++) begin
            if (sel_hot[n]) begin
              len_d[n]   = written;
              valid_d[n] = (written != '0);
            end
          end
        end
      end
      PLAY: begin
        if (sample_tick_i) begin
          mem_addr_d = {sel_q, addr_q};
          if ({1'b0, addr_q} == sel_len - LenW'(1)) begin
            state_d = IDLE;
          end else begin
            addr_d = addr_q + AddrW'(1);
          end
        end
        if (play_press) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    play_clip_d   = (state_d == PLAY)   ? sel_d : CLIP_NONE;
    record_clip_d = (state_d == RECORD) ? sel_d : CLIP_NONE;
  end

  // State and output registers; reset also discards any recording in progress.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      addr_q        <= '0;
      valid_q       <= '0;
      len_q         <= '0;
      play_clip_q   <= CLIP_NONE;
      record_clip_q <= CLIP_NONE;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      addr_q        <= addr_d;
      valid_q       <= valid_d;
      len_q         <= len_d;
      play_clip_q   <= play_clip_d;
      record_clip_q <= record_clip_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
    end
  end

  assign play_clip_o   = play_clip_q;
  assign record_clip_o = record_clip_q;
  assign selected_o    = sel_q;
  assign clip_valid_o  = valid_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_we_o      = mem_we_q;

endmodule
